// File: rtl/md_pkg.sv
// Op codes, FSM states and op classification shared by the multiply/divide unit.
// Define MD_MADD_EN to run ops 6/7 as MADD/MSUB; otherwise they are no-ops.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MSUB  = 3'd7;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for several cycles and therefore raise busy.
  function automatic logic md_is_long(input logic [2:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MSUB);
`else
    r = r;
`endif
    return r;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational result datapath for multiply/divide ops, producing the new {hi,lo}.
// Holds every signedness, divide-by-zero and overflow rule; the controller only sequences.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_acc,
  input  logic [31:0] lo_acc,
  input  logic [31:0] hi_old,
  input  logic [31:0] lo_old,
  output logic [63:0] res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic        is_sdiv;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Signed divide works on magnitudes so INT_MIN / -1 simply wraps to INT_MIN with
  // remainder 0; a zero divisor is replaced by 1 only to keep the divider defined.
  always_comb begin
    prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u  = {32'b0, a} * {32'b0, b};
    acc     = {hi_acc, lo_acc};
    is_sdiv = (op == MD_DIV);
    neg_a   = is_sdiv & a[31];
    neg_b   = is_sdiv & b[31];
    mag_a   = neg_a ? (32'd0 - a) : a;
    if (b == 32'd0)
      div_b = 32'd1;
    else
      div_b = neg_b ? (32'd0 - b) : b;
    q_mag   = mag_a / div_b;
    r_mag   = mag_a % div_b;
    quot    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem     = neg_a ? (32'd0 - r_mag) : r_mag;

    res = {hi_old, lo_old};
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_MADD:  res = acc + prod_s;
      MD_MSUB:  res = acc - prod_s;
      MD_DIV,
      MD_DIVU:  if (b != 32'd0) res = {rem, quot};
      default:  res = {hi_old, lo_old};
    endcase
  end

endmodule

// File: rtl/md_controller.sv
// Multiply/divide sequencer owning HI/LO: latches operands, counts fixed latency, raises stall.
// MADD/MSUB support is selected at build time by the MD_MADD_EN macro (see md_pkg).
module md_controller
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_acc_q;
  logic [31:0]      lo_acc_q;
  logic [63:0]      res;
  logic             start_long;

  assign start_long = start & md_is_long(md_op);
  // The start-cycle term covers the cycle before busy rises.
  assign md_stall   = md_use_d & (busy | start_long);

  md_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_acc (hi_acc_q),
    .lo_acc (lo_acc_q),
    .hi_old (hi),
    .lo_old (lo),
    .res    (res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_q     <= MD_MULT;
      a_q      <= '0;
      b_q      <= '0;
      hi_acc_q <= '0;
      lo_acc_q <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            if (md_is_long(md_op)) begin
              op_q     <= md_op;
              a_q      <= rs_val;
              b_q      <= rt_val;
              hi_acc_q <= hi;
              lo_acc_q <= lo;
              cnt      <= md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              busy     <= 1'b1;
              state    <= MD_RUN;
            end else if (md_op == MD_MTHI) begin
              hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        MD_RUN: begin
          // A start here is a hazard-unit violation and is deliberately ignored.
          if (cnt == CNT_W'(1)) begin
            hi    <= res[63:32];
            lo    <= res[31:0];
            cnt   <= '0;
            busy  <= 1'b0;
            state <= MD_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_controller.sv
// Scoreboard bench for md_controller: a reference model queues expected hi/lo/latency per op,
// and a monitor checks them plus md_stall when each op completes.
`timescale 1ns/1ps
module tb_md_controller;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  md_controller #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_d (md_use_d),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Architectural behaviour of one op on the programmer-visible HI/LO pair.
  task automatic refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] h, inout logic [31:0] l, output int lat);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 0;
    case (op)
      3'd0: begin p = 64'(sa * sb); {h, l} = p; lat = MULT_CYCLES; end
      3'd1: begin p = 64'(longint'({32'b0, a}) * longint'({32'b0, b})); {h, l} = p; lat = MULT_CYCLES; end
      3'd2: begin
        lat = DIV_CYCLES;
        if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
      end
      3'd3: begin
        lat = DIV_CYCLES;
        if (b != 0) begin l = a / b; h = a % b; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: begin
`ifdef MD_MADD_EN
        acc = {h, l};
        p   = 64'(sa * sb);
        acc = (op == 3'd6) ? acc + p : acc - p;
        {h, l} = acc;
        lat = MULT_CYCLES;
`else
        acc = {h, l};
        p   = acc;
`endif
      end
    endcase
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit use_d, input int reset_at);
    exp_t        e;
    int          lat;
    logic [31:0] h;
    logic [31:0] l;
    h = hi_m;
    l = lo_m;
    refModel(op, a, b, h, l, lat);
    if (reset_at > 0 && reset_at <= lat) begin
      h   = 32'd0;
      l   = 32'd0;
      lat = reset_at;
    end
    hi_m   = h;
    lo_m   = l;
    e.hi   = h;
    e.lo   = l;
    e.lat  = lat;
    e.name = name;
    sb_q.push_back(e);

    @(posedge clk); #1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    md_use_d = use_d;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    md_op  = 3'($urandom_range(0, 7));
    if (reset_at > 0) begin
      repeat (reset_at - 1) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
    for (int i = 0; i < 64 && busy; i++) begin @(posedge clk); #1; end
    checkOutput({name, "_done_in_time"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every accepted start pops one expectation and follows the op to completion.
  initial begin : monitor
    exp_t e;
    int   n;
    forever begin
      @(negedge clk);
      if (start && busy) begin
        checks++;
        $display("[TB] FAIL start_while_busy actual=1 required=0");
      end else if (start) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL scoreboard_empty actual=0 required=1");
        end else begin
          e = sb_q.pop_front();
          checkOutput({e.name, "_stall_start"}, 64'(md_stall), 64'(md_use_d && e.lat > 0));
          n = 0;
          @(negedge clk);
          while (busy && n < 64) begin
            checkOutput({e.name, "_stall_busy"}, 64'(md_stall), 64'(md_use_d));
            n++;
            @(negedge clk);
          end
          checkOutput({e.name, "_busy_cycles"}, 64'(n), 64'(e.lat));
          checkOutput({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          checkOutput({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          checkOutput({e.name, "_stall_done"}, 64'(md_stall), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = 3'd0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    md_use_d = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_stall", 64'(md_stall), 64'd0);

    applyStimulus("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
    applyStimulus("mthi", 3'd4, 32'h11, 32'd0, 1'b1, 0);
    applyStimulus("mtlo", 3'd5, 32'h22, 32'd0, 1'b0, 0);
    applyStimulus("div_zero", 3'd2, 32'd5, 32'd0, 1'b1, 0);
    applyStimulus("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    applyStimulus("divu", 3'd3, 32'd7, 32'd2, 1'b0, 0);
    applyStimulus("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    applyStimulus("mthi0", 3'd4, 32'd0, 32'd0, 1'b0, 0);
    applyStimulus("mtlo_ones", 3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    applyStimulus("madd", 3'd6, 32'd1, 32'd1, 1'b1, 0);
    applyStimulus("msub", 3'd7, 32'd3, 32'hFFFF_FFFE, 1'b1, 0);
    applyStimulus("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    applyStimulus("div_reset", 3'd2, 32'd100, 32'd7, 1'b1, 3);
    applyStimulus("mult_after_reset", 3'd0, 32'h1234, 32'h5678, 1'b1, 0);

    for (int i = 0; i < 60; i++)
      applyStimulus($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pickOperand(),
                    pickOperand(), 1'($urandom_range(0, 1)), 0);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
